// File: rtl/dla_axi_lite_pkg.sv
// Shared types and constants for the DLA AXI-Lite register subordinate.
// Response codes plus write/read channel FSM state encodings.
package dla_axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_EXEC,
        W_RESP
    } sub_wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } sub_rd_state_t;

endpackage

// File: rtl/dla_axi_lite_if.sv
// AXI-Lite bundle: AW, W, B, AR and R channels with valid/ready handshakes.
// Slave modport for the register end, Master modport for the requester.
interface AXI_LITE #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]                  aw_prot;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_valid;
    logic                        w_ready;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_valid;
    logic                        r_ready;

    modport Slave (
        input  aw_addr, aw_prot, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

    modport Master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );
endinterface

// File: rtl/dla_axi_lite_addr_dec.sv
// Combinational register decoder: byte address -> (hit, register index).
// Ports: addr in; hit out (address inside the bank); idx out (word index).
module dla_axi_lite_addr_dec
    import dla_axi_lite_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int NUM_REGS  = 8,
    parameter int BASE_ADDR = 0,
    parameter int IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);
    localparam int LSB = $clog2(DW / 8);

    logic [AW-1:0] offset;
    logic [AW-1:0] word;

    // Byte-lane bits drop out of the shift, so unaligned addresses alias.
    assign offset = addr - AW'(BASE_ADDR);
    assign word   = offset >> LSB;
    assign hit    = (addr >= AW'(BASE_ADDR)) && (word < AW'(NUM_REGS));
    assign idx    = word[IW-1:0];
endmodule

// File: rtl/dla_axi_lite_sub.sv
// AXI-Lite subordinate fronting NUM_REGS control/status registers.
// Ports: clk_i, rstn_i (sync, low), pp_if (AXI-Lite slave), regs_o, wr/rd pulses.
module dla_axi_lite_sub
    import dla_axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 8,
    parameter int BASE_ADDR      = 0
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    AXI_LITE.Slave                             pp_if,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                wr_pulse_o,
    output logic [NUM_REGS-1:0]                rd_pulse_o
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DW-1:0] regs [NUM_REGS];

    sub_wr_state_t wr_state, wr_state_n;
    sub_rd_state_t rd_state, rd_state_n;

    logic          aw_ready, aw_ready_n, w_ready, w_ready_n;
    logic          b_valid, b_valid_n;
    logic [1:0]    b_resp, b_resp_n;
    logic          ar_ready, ar_ready_n, r_valid, r_valid_n;
    logic [1:0]    r_resp, r_resp_n;
    logic [DW-1:0] r_data, r_data_n, rd_word;
    logic          wr_commit, rd_fire;

    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    logic          whit, rhit;
    logic [IW-1:0] widx, ridx;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = pp_if.aw_valid & aw_ready;
    assign w_hs  = pp_if.w_valid & w_ready;
    assign b_hs  = b_valid & pp_if.b_ready;
    assign ar_hs = pp_if.ar_valid & ar_ready;
    assign r_hs  = r_valid & pp_if.r_ready;

    assign pp_if.aw_ready = aw_ready;
    assign pp_if.w_ready  = w_ready;
    assign pp_if.b_valid  = b_valid;
    assign pp_if.b_resp   = b_resp;
    assign pp_if.ar_ready = ar_ready;
    assign pp_if.r_valid  = r_valid;
    assign pp_if.r_resp   = r_resp;
    assign pp_if.r_data   = r_data;

    dla_axi_lite_addr_dec #(
        .AW(AW), .DW(DW), .NUM_REGS(NUM_REGS),
        .BASE_ADDR(BASE_ADDR), .IW(IW)
    ) u_wdec (.addr(waddr), .hit(whit), .idx(widx));

    dla_axi_lite_addr_dec #(
        .AW(AW), .DW(DW), .NUM_REGS(NUM_REGS),
        .BASE_ADDR(BASE_ADDR), .IW(IW)
    ) u_rdec (.addr(pp_if.ar_addr), .hit(rhit), .idx(ridx));

    always_comb begin
        wr_state_n = wr_state;
        aw_ready_n = aw_ready;
        w_ready_n  = w_ready;
        b_valid_n  = b_valid;
        b_resp_n   = b_resp;
        wr_commit  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                // Readys come up here on the first edge out of reset.
                aw_ready_n = 1'b1;
                w_ready_n  = 1'b1;
                if (aw_hs && w_hs) begin
                    wr_state_n = W_EXEC;
                    aw_ready_n = 1'b0;
                    w_ready_n  = 1'b0;
                end else if (aw_hs) begin
                    wr_state_n = W_HAVE_AW;
                    aw_ready_n = 1'b0;
                end else if (w_hs) begin
                    wr_state_n = W_HAVE_W;
                    w_ready_n  = 1'b0;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                wr_state_n = W_EXEC;
                w_ready_n  = 1'b0;
            end
            W_HAVE_W: if (aw_hs) begin
                wr_state_n = W_EXEC;
                aw_ready_n = 1'b0;
            end
            W_EXEC: begin
                wr_commit  = 1'b1;
                b_valid_n  = 1'b1;
                b_resp_n   = whit ? RESP_OKAY : RESP_SLVERR;
                wr_state_n = W_RESP;
            end
            W_RESP: if (b_hs) begin
                b_valid_n  = 1'b0;
                aw_ready_n = 1'b1;
                w_ready_n  = 1'b1;
                wr_state_n = W_IDLE;
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // Index by comparison so a miss on a non-power-of-2 bank never indexes past the end.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ridx == IW'(i)) rd_word = regs[i];
    end

    always_comb begin
        rd_state_n = rd_state;
        ar_ready_n = ar_ready;
        r_valid_n  = r_valid;
        r_resp_n   = r_resp;
        r_data_n   = r_data;
        rd_fire    = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ar_ready_n = 1'b1;
                if (ar_hs) begin
                    rd_fire    = 1'b1;
                    r_valid_n  = 1'b1;
                    ar_ready_n = 1'b0;
                    r_data_n   = rhit ? rd_word : '0;
                    r_resp_n   = rhit ? RESP_OKAY : RESP_SLVERR;
                    rd_state_n = R_RESP;
                end
            end
            R_RESP: if (r_hs) begin
                r_valid_n  = 1'b0;
                ar_ready_n = 1'b1;
                rd_state_n = R_IDLE;
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_state   <= W_IDLE;
            rd_state   <= R_IDLE;
            aw_ready   <= 1'b0;
            w_ready    <= 1'b0;
            b_valid    <= 1'b0;
            b_resp     <= 2'b00;
            ar_ready   <= 1'b0;
            r_valid    <= 1'b0;
            r_resp     <= 2'b00;
            r_data     <= '0;
            waddr      <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            wr_pulse_o <= '0;
            rd_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
            aw_ready <= aw_ready_n;
            w_ready  <= w_ready_n;
            b_valid  <= b_valid_n;
            b_resp   <= b_resp_n;
            ar_ready <= ar_ready_n;
            r_valid  <= r_valid_n;
            r_resp   <= r_resp_n;
            r_data   <= r_data_n;
            if (aw_hs) waddr <= pp_if.aw_addr;
            if (w_hs) begin
                wdata <= pp_if.w_data;
                wstrb <= pp_if.w_strb;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse_o[i] <= wr_commit && whit && (widx == IW'(i));
                rd_pulse_o[i] <= rd_fire && rhit && (ridx == IW'(i));
                if (wr_commit && whit && (widx == IW'(i)))
                    for (int b = 0; b < NB; b++)
                        if (wstrb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DW +: DW] = regs[g];
    end
endmodule

// File: doc/dla_axi_lite_sub.md
# dla_axi_lite_sub

AXI-Lite subordinate exposing a bank of `NUM_REGS` control/status registers to an AXI-Lite manager, such as the DLA-side manager. It sits at the register end of the AXI-Lite link and drives the register contents and per-register access pulses into user logic. The write and read channels are handled by two independent, non-pipelined FSMs, each with one outstanding transaction.

## Interface
- `AXI_ADDR_WIDTH`, 16: address width.
- `AXI_DATA_WIDTH`, 32: data width; byte count `NB = AXI_DATA_WIDTH/8`.
- `NUM_REGS`, 8: number of registers, ≥1.
- `BASE_ADDR`, 0: byte address of register 0; must be NB-aligned.
- `clk_i  in  1`: clock; the single clock domain.
- `rstn_i  in  1`: reset, synchronous and active-low.
- `regs_o  out  NUM_REGS*AXI_DATA_WIDTH`: register contents, flattened; register i occupies bits [i*DW +: DW].
- `wr_pulse_o  out  NUM_REGS`: one-cycle pulse per register when it is written.
- `rd_pulse_o  out  NUM_REGS`: one-cycle pulse per register when it is read.
- `pp_if  AXI_LITE.Slave`: AXI-Lite subordinate port. `aw_prot` and `ar_prot` are ignored.

## Operation
- **Decode:** `idx = (addr - BASE_ADDR) >> log2(NB)`.
  - Hit when `addr >= BASE_ADDR` and `idx < NUM_REGS`.
  - The low log2(NB) address bits are ignored.
- **Write FSM states:** W_IDLE, W_HAVE_AW, W_HAVE_W, W_EXEC, W_RESP.
  - **W_IDLE:** `aw_ready=1`, `w_ready=1`. AW and W may arrive in either order or in the same cycle.
  - **AW only:** latch the address, drop `aw_ready`, go to W_HAVE_AW.
  - **W only:** latch data and strobe, drop `w_ready`, go to W_HAVE_W.
  - **Both handshakes in one cycle:** go straight to W_EXEC.
  - **W_HAVE_AW:** on W handshake, go to W_EXEC.
  - **W_HAVE_W:** on AW handshake, go to W_EXEC.
  - **W_EXEC:** both readys are 0.
    - On a hit, write byte lane b only where `w_strb[b]=1` and pulse `wr_pulse_o[idx]`.
    - Set `b_resp` to 2'b00 on a hit, or 2'b10 (SLVERR) on a miss with no register change.
    - Assert `b_valid`, go to W_RESP.
  - **W_RESP:** hold `b_valid`/`b_resp` until `b_ready`. On the handshake, clear `b_valid`, raise `aw_ready`/`w_ready`, go to W_IDLE.
- **Read FSM states:** R_IDLE, R_RESP.
  - **R_IDLE:** `ar_ready=1`. On AR handshake:
    - Register `r_data` = reg[idx] on a hit, or 0 on a miss.
    - Set `r_resp` to OKAY on a hit, or SLVERR on a miss.
    - Assert `r_valid`, drop `ar_ready`, pulse `rd_pulse_o[idx]` on a hit, go to R_RESP.
  - **R_RESP:** hold `r_valid`, `r_data` and `r_resp` stable until `r_ready`. On the handshake, clear `r_valid`, raise `ar_ready`, go to R_IDLE.
- **Simultaneous read and write:** an AR handshake in the same edge as a W_EXEC commit to the same register returns the old value.
- **Stalls:** a stalled B channel never blocks reads, and a stalled R channel never blocks writes.

## Timing
- **Reset values** (applied while `rstn_i=0` at a clock edge):
  - All readys 0, `b_valid`/`r_valid` 0, `b_resp`/`r_resp` 0, `r_data` 0.
  - `regs_o` 0, both pulse vectors 0, both FSMs idle.
- **After reset:** readys are 1 from the first edge after `rstn_i` rises.
- **Write latency:**
  - Final AW/W handshake at edge k: register updated and `b_valid`=1 after edge k+1.
  - `wr_pulse_o` is high for the cycle after edge k+1.
  - With `b_ready` held high, B handshakes at k+2 and readys return after k+2, giving a minimum of 3 cycles per write.
- **Read latency:**
  - AR handshake at edge k: `r_valid`=1 and `rd_pulse_o` high after edge k.
  - With `r_ready` high, R handshakes at k+1, giving a minimum of 2 cycles per read.
- **Pulses:** exactly one cycle wide, at most one bit set per vector.
- **Reset mid-transaction:** in-flight transactions are abandoned with no B/R response; registers return to 0.

## Structure
- Shared package `dla_axi_lite_pkg`:
  - `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
  - Enums `sub_wr_state_t` and `sub_rd_state_t`.
- Sub-module `dla_axi_lite_addr_dec`: combinational `addr` → (`hit`, `idx`). It is instantiated twice, once for the write channel and once for the read channel.

## Test plan
- **Aligned write then read:**
  - Stimulus: AW=0x0004 and W=0xDEADBEEF/strb 0xF in the same cycle, `b_ready`=1; then AR=0x0004.
  - Required: `regs_o[1]`=0xDEADBEEF, `b_resp`=OKAY 2 edges after AW/W, `wr_pulse_o`=8'h02 for one cycle; `r_data`=0xDEADBEEF, `rd_pulse_o`=8'h02.
- **W before AW, partial strobe:**
  - Stimulus: reg2=0x11223344; W=0xAABBCCDD/strb 0x5 three cycles before AW=0x0008.
  - Required: reg2=0x11BB33DD, single B response.
- **Out of range:**
  - Stimulus: write to 0x0020 with NUM_REGS=8, then read 0x0020.
  - Required: `b_resp`=SLVERR, no `wr_pulse_o`, all registers unchanged; `r_data`=0, `r_resp`=SLVERR.
- **Backpressure:**
  - Stimulus: hold `b_ready`=0 for 5 cycles while issuing a read.
  - Required: read completes; `b_valid` and `b_resp` stay stable for the 5 cycles; `aw_ready`=0 throughout.
- **Same-edge collision:**
  - Stimulus: reg0=0x1, write 0x2 to reg0 committing in the same edge as AR=0x0000.
  - Required: `r_data`=0x1, then reg0=0x2.
- **Reset mid-operation:**
  - Stimulus: AW accepted, `rstn_i`=0 for 1 cycle before W.
  - Required: no `b_valid`, `regs_o`=0, readys high one edge after release.
